// File: rtl/ex_mem_stage.sv
// Execute stage of the 8-bit core: ALU, iterative multiplier and the
// EX/MEM pipeline register feeding the MEM stage.
module ex_mem_stage #(
  parameter int DATA_W     = 8,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              memwrite_in,
  input  logic              memread_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  input  logic              alusrc_in,
  input  logic [1:0]        aluop_in,
  input  logic [2:0]        func3_in,
  input  logic [6:0]        func7_in,
  input  logic [4:0]        rd_in,
  input  logic [DATA_W-1:0] readdata1_in,
  input  logic [DATA_W-1:0] readdata2_in,
  input  logic [DATA_W-1:0] imm_data_in,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        rd,
  output logic              memwrite,
  output logic              memread,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              zero
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic {EXEC, MUL} state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] op_a, op_b, res;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_n;
  logic [CW-1:0]     cnt;
  logic [4:0]        mul_rd;
  logic [3:0]        mul_ctrl;
  logic [2:0]        shamt;
  logic              res_zero, is_mul, mul_last;

  assign op_a     = readdata1_in;
  assign op_b     = alusrc_in ? imm_data_in : readdata2_in;
  assign shamt    = op_b[2:0];
  assign is_mul   = (aluop_in == 2'b10) &&
                    (func7_in == 7'b0000001) && !alusrc_in;
  assign mul_last = (cnt == LAST);
  assign acc_n    = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res      = '0;
    res_zero = 1'b0;
    unique case (aluop_in)
      2'b00: res = op_a + op_b;
      2'b01: begin
        res      = op_a - op_b;
        res_zero = (res == '0);
      end
      2'b11: res = op_b;
      default: begin
        unique case (func3_in)
          3'b000: begin
            if (func7_in[5] && !alusrc_in) res = op_a - op_b;
            else                           res = op_a + op_b;
          end
          3'b001: res = op_a << shamt;
          3'b010: res = {{(DATA_W-1){1'b0}},
                         $signed(op_a) < $signed(op_b)};
          3'b011: res = {{(DATA_W-1){1'b0}}, op_a < op_b};
          3'b100: res = op_a ^ op_b;
          3'b101: begin
            if (func7_in[5]) res = $signed(op_a) >>> shamt;
            else             res = op_a >> shamt;
          end
          3'b110: res = op_a | op_b;
          default: res = op_a & op_b;
        endcase
      end
    endcase
  end

  // Final multiply iteration drops stall so ID/EX advances with the result.
  always_comb begin
    stall = 1'b0;
    if (reset && !flush) begin
      if (state == EXEC) stall = in_valid && is_mul;
      else               stall = !mul_last;
    end
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = EXEC;
    end else if (state == EXEC) begin
      if (in_valid && is_mul) state_n = MUL;
    end else if (mul_last) begin
      state_n = EXEC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EXEC;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      store_data <= '0;
      rd         <= '0;
      memwrite   <= 1'b0;
      memread    <= 1'b0;
      memtoreg   <= 1'b0;
      regwrite   <= 1'b0;
      zero       <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      mul_rd     <= '0;
      mul_ctrl   <= '0;
    end else begin
      out_valid <= 1'b0;
      memwrite  <= 1'b0;
      memread   <= 1'b0;
      memtoreg  <= 1'b0;
      regwrite  <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (state == EXEC) begin
        if (in_valid && is_mul) begin
          mcand    <= op_a;
          mplier   <= op_b;
          acc      <= '0;
          cnt      <= '0;
          mul_rd   <= rd_in;
          mul_ctrl <= {memwrite_in, memread_in,
                       memtoreg_in, regwrite_in};
        end else if (in_valid) begin
          out_valid  <= 1'b1;
          alu_result <= res;
          zero       <= res_zero;
          store_data <= readdata2_in;
          rd         <= rd_in;
          memwrite   <= memwrite_in;
          memread    <= memread_in;
          memtoreg   <= memtoreg_in;
          regwrite   <= regwrite_in;
        end
      end else begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          out_valid  <= 1'b1;
          alu_result <= acc_n;
          zero       <= 1'b0;
          rd         <= mul_rd;
          {memwrite, memread, memtoreg, regwrite} <= mul_ctrl;
          cnt        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: random and directed instructions
// checked against an arithmetic reference model.
module tb_ex_mem_stage;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid;
  logic       memwrite_in, memread_in, memtoreg_in, regwrite_in;
  logic       alusrc_in;
  logic [1:0] aluop_in;
  logic [2:0] func3_in;
  logic [6:0] func7_in;
  logic [4:0] rd_in;
  logic [7:0] readdata1_in, readdata2_in, imm_data_in;
  logic       stall, out_valid;
  logic [7:0] alu_result, store_data;
  logic [4:0] rd;
  logic       memwrite, memread, memtoreg, regwrite, zero;

  ex_mem_stage #(.DATA_W(8), .MUL_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .memwrite_in(memwrite_in), .memread_in(memread_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .alusrc_in(alusrc_in), .aluop_in(aluop_in),
    .func3_in(func3_in), .func7_in(func7_in), .rd_in(rd_in),
    .readdata1_in(readdata1_in), .readdata2_in(readdata2_in),
    .imm_data_in(imm_data_in), .stall(stall),
    .out_valid(out_valid), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .memwrite(memwrite),
    .memread(memread), .memtoreg(memtoreg), .regwrite(regwrite),
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int z; int rdv; int ctrl; int sd; bit is_mul;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
                  name, act, act, req, req, $time);
  endtask

  function automatic int sx(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference model driven by the rules for each operation class.
  function automatic exp_t predict();
    exp_t e;
    int a, b, sh, r, z;
    bit m;
    a  = readdata1_in;
    b  = alusrc_in ? imm_data_in : readdata2_in;
    sh = b % 8;
    r  = 0;
    z  = 0;
    m  = (aluop_in == 2) && (func7_in == 1) && !alusrc_in;
    if (m) r = (a * b) % 256;
    else case (aluop_in)
      0: r = (a + b) % 256;
      1: begin r = (a - b + 256) % 256; z = (a == b); end
      3: r = b;
      default: case (func3_in)
        0: r = (func7_in[5] && !alusrc_in) ? (a - b + 256) % 256
                                           : (a + b) % 256;
        1: r = (a * (2 ** sh)) % 256;
        2: r = (sx(a) < sx(b)) ? 1 : 0;
        3: r = (a < b) ? 1 : 0;
        4: r = a ^ b;
        5: r = func7_in[5] ? ((sx(a) >>> sh) & 255) : a / (2 ** sh);
        6: r = a | b;
        default: r = a & b;
      endcase
    endcase
    e.res = r;
    e.z = z;
    e.rdv = rd_in;
    e.ctrl = {memwrite_in, memread_in, memtoreg_in, regwrite_in};
    e.sd = readdata2_in;
    e.is_mul = m;
    return e;
  endfunction

  task automatic set_instr(input int op, input int f3, input int f7,
                           input int src, input int a, input int b,
                           input int imm, input int rdv, input int ctrl);
    aluop_in = op[1:0];
    func3_in = f3[2:0];
    func7_in = f7[6:0];
    alusrc_in = src[0];
    readdata1_in = a[7:0];
    readdata2_in = b[7:0];
    imm_data_in = imm[7:0];
    rd_in = rdv[4:0];
    {memwrite_in, memread_in, memtoreg_in, regwrite_in} = ctrl[3:0];
    in_valid = 1'b1;
  endtask

  // Called at a negedge; holds the instruction until stall is low at an edge.
  task automatic issue(input int op, input int f3, input int f7,
                       input int src, input int a, input int b,
                       input int imm, input int rdv, input int ctrl,
                       output int stalls);
    bit s, done;
    set_instr(op, f3, f7, src, a, b, imm, rdv, ctrl);
    flush = 1'b0;
    q.push_back(predict());
    stalls = 0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      #1 s = stall;
      @(posedge clk);
      @(negedge clk);
      if (!s) begin done = 1; break; end
      stalls++;
    end
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      memwrite_in = 1'($urandom);
      regwrite_in = 1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            chk("alu_result", alu_result, e.res);
            chk("zero", zero, e.z);
            chk("rd", rd, e.rdv);
            chk("ctrl", {memwrite, memread, memtoreg, regwrite}, e.ctrl);
            if (!e.is_mul) chk("store_data", store_data, e.sd);
          end
        end else begin
          chk("bubble_ctrl", {memwrite, memread, memtoreg, regwrite}, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int st, op, f7, src;
    reset = 1'b0;
    flush = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_ctrl", {memwrite, memread, memtoreg, regwrite}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);

    issue(0, 0, 0, 1, 100, 0, 27, 5, 4'b0100, st);
    chk("load_latency", out_valid, 1);
    chk("load_result", alu_result, 127);
    chk("load_memread", memread, 1);
    chk("load_rd", rd, 5);
    issue(1, 0, 0, 0, 5, 7, 0, 0, 0, st);
    chk("beq_diff", alu_result, 'hFE);
    chk("beq_diff_zero", zero, 0);
    issue(1, 0, 0, 0, 'h3C, 'h3C, 0, 0, 0, st);
    chk("beq_eq_zero", zero, 1);
    issue(2, 5, 0, 0, 'h90, 2, 0, 3, 1, st);
    chk("srl", alu_result, 'h24);
    issue(2, 5, 'h20, 0, 'h90, 2, 0, 3, 1, st);
    chk("sra", alu_result, 'hE4);
    issue(2, 1, 0, 0, 'h11, 'h0B, 0, 3, 1, st);
    chk("sll", alu_result, 'h88);

    issue(2, 0, 1, 0, 13, 11, 0, 9, 1, st);
    chk("mul_stall_cycles", st, 8);
    chk("mul_result", alu_result, 'h8F);
    chk("mul_rd", rd, 9);
    issue(0, 0, 0, 1, 3, 0, 4, 2, 1, st);
    chk("add_after_mul_stall", st, 0);
    chk("add_after_mul", alu_result, 7);
    issue(2, 0, 1, 0, 'hFF, 'hFF, 0, 4, 1, st);
    chk("mul_ff", alu_result, 1);

    idle(1);
    memwrite_in = 1'b1;
    @(negedge clk);
    chk("bubble_memwrite", memwrite, 0);

    // Flush at iteration 4 of a multiply.
    set_instr(2, 0, 1, 0, 13, 11, 0, 6, 1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b0;
    #1 chk("flush_stall", stall, 0);
    @(posedge clk);
    #1 chk("flush_out_valid", out_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    idle(12);
    issue(0, 0, 0, 1, 1, 0, 1, 1, 1, st);
    chk("post_flush_stall", st, 0);
    chk("post_flush_add", alu_result, 2);
    set_instr(0, 0, 0, 1, 9, 0, 9, 1, 1);
    flush = 1'b1;
    @(negedge clk);
    idle(3);

    // Asynchronous reset in the middle of a multiply.
    set_instr(2, 0, 1, 0, 13, 11, 0, 8, 1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_alu_result", alu_result, 0);
    chk("arst_rd", rd, 0);
    chk("arst_ctrl", {memwrite, memread, memtoreg, regwrite}, 0);
    chk("arst_stall", stall, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(12);
    issue(0, 0, 0, 1, 20, 0, 22, 3, 1, st);
    chk("post_reset_stall", st, 0);
    chk("post_reset_add", alu_result, 42);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      op = $urandom_range(0, 3);
      src = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: f7 = 0;
        1: f7 = 'h20;
        2: f7 = 1;
        default: f7 = $urandom_range(0, 127);
      endcase
      if ($urandom_range(0, 7) == 0) begin op = 2; f7 = 1; src = 0; end
      issue(op, $urandom_range(0, 7), f7, src, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 31), $urandom_range(0, 15), st);
    end
    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage of the 8-bit pipelined core. It consumes the ID/EX register bundle and computes the ALU result.
- It owns the EX/MEM pipeline register: results, store data, destination register and memory/writeback controls are registered for the MEM stage.
- Most operations complete in one cycle. MUL runs on an iterative shift-add multiplier, and the stage stalls the upstream ID/EX register while the multiply is in progress.

Parameters:
- DATA_W, 8, datapath width (operands, result, store data).
- MUL_CYCLES, DATA_W, number of shift-add iterations for MUL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; the block is in reset while reset==0.
- flush  in  1  synchronous kill of the instruction in EX (branch redirect).
- in_valid  in  1  ID/EX bundle holds a real instruction.
- memwrite_in, memread_in, memtoreg_in, regwrite_in, alusrc_in  in  1 each  ID/EX controls.
- aluop_in  in  2  ID/EX ALU op class.
- func3_in  in  3  ID/EX funct3.
- func7_in  in  7  ID/EX funct7.
- rd_in  in  5  destination register.
- readdata1_in, readdata2_in  in  DATA_W  register operands.
- imm_data_in  in  DATA_W  immediate.
- stall  out  1  ID/EX must hold its contents this cycle.
- out_valid  out  1  EX/MEM holds a real instruction.
- alu_result  out  DATA_W  registered result or address.
- store_data  out  DATA_W  registered readdata2 for stores.
- rd  out  5  registered destination register.
- memwrite, memread, memtoreg, regwrite  out  1 each  registered controls.
- zero  out  1  registered (A-B)==0 flag.

Behaviour:
- Operands: A = readdata1_in; B = alusrc_in ? imm_data_in : readdata2_in.
- All arithmetic is modulo 2^DATA_W. There are no overflow or carry outputs.
- aluop decode:
  - 00: A+B (load/store address).
  - 01: A-B; zero=(A-B==0).
  - 11: pass B.
  - 10: decode by func3:
    - 000: add, or sub when func7[5]=1 and alusrc_in=0.
    - 001: sll, shift amount B[2:0].
    - 010: slt, signed, result 1 or 0.
    - 011: sltu, result 1 or 0.
    - 100: xor.
    - 101: srl, or sra when func7[5]=1; shift amount B[2:0].
    - 110: or.
    - 111: and.
  - MUL overrides the func3 decode when aluop_in=10, func7_in=7'b0000001 and alusrc_in=0. The result is the low DATA_W bits of A*B, unsigned.
- zero is 0 for every aluop other than 01.
- FSM states: EXEC, MUL. Reset state is EXEC.
- EXEC, in_valid=1, not MUL:
  - All EX/MEM outputs load at the next edge with out_valid=1. Latency is 1 cycle.
  - stall=0.
- EXEC, in_valid=1, MUL:
  - stall=1 combinationally.
  - Capture A as multiplicand and B as multiplier; acc=0, cnt=0; go to MUL.
  - At that edge out_valid<=0 and all four control outputs go to 0 (bubble).
- MUL, each cycle:
  - If multiplier[0]=1, acc+=multiplicand.
  - multiplicand<<=1; multiplier>>=1; cnt++.
  - stall=1 while cnt<MUL_CYCLES-1. stall=0 on the final iteration, so ID/EX advances at the same edge the result is written.
  - The final iteration's edge loads alu_result=acc (including the last add), the rd/controls captured at decode, out_valid=1, zero=0; go to EXEC.
  - Total: the MUL result is registered MUL_CYCLES+1 edges after the MUL is first presented; stall is high for MUL_CYCLES cycles.
- Inputs are ignored while in state MUL. The upstream register must hold them.
- in_valid=0 in EXEC: bubble at the next edge. out_valid=0 and memwrite/memread/memtoreg/regwrite=0. Data outputs may hold their old values.
- out_valid=0 always forces the four control outputs to 0. A bubble never writes memory or registers.
- flush=1 has priority over everything:
  - Next edge: bubble, FSM to EXEC, cnt cleared, any multiply abandoned.
  - stall=0 in the flush cycle.
- reset (asynchronous, low): all outputs 0, FSM EXEC, acc/cnt/operand registers 0, stall=0. This includes reset during a multiply; no partial result may emerge after release.
- in_valid with flush on the same cycle: the instruction is dropped.

Test Plan:
- Load address: aluop=00, alusrc=1, A=100, imm=27, memread=1, rd=5 -> next edge alu_result=127, memread=1, rd=5, out_valid=1.
- Branch compare (aluop=01): A=5, B=7 -> alu_result=0xFE, zero=0. A=B=0x3C -> zero=1.
- Shifts: A=0x90, B=2, func3=101 -> func7[5]=0 gives 0x24; func7[5]=1 gives 0xE4. func3=001 with B=0x0B (shift 3) on A=0x11 gives 0x88.
- Multiply:
  - 13*11: stall high for 8 cycles, out_valid=0 for 8 edges, then alu_result=0x8F, out_valid=1. An add presented behind it completes on the following edge.
  - 0xFF*0xFF -> 0x01.
- Flush during MUL at iteration 4 -> next edge out_valid=0, stall=0, FSM EXEC. No MUL result appears later.
- Bubble safety and reset:
  - in_valid=0 with memwrite_in=1 -> memwrite output stays 0.
  - reset pulled low mid-MUL -> all outputs 0 immediately, without waiting for clk. After release, the first valid add completes normally.
